// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive blocks.
//   - DEF_BAUD_DIV / DEF_OVERSAMPLE / DEF_DATA_BITS : default line timing so
//     the transmitter and receiver agree on bit period and frame width.
//   - rx_state_t : receiver frame-tracking states.
//   - majority3  : 2-of-3 vote used to filter noise around mid-bit.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_BAUD_DIV   = 4;   // clock cycles per oversample tick
  localparam int DEF_OVERSAMPLE = 16;  // ticks per bit period
  localparam int DEF_DATA_BITS  = 8;   // data bits per frame, LSB first

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

  // 2-of-3 majority of the three mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os_if
// Line/host side signal bundle of the oversampling UART receiver.
//   SI      : asynchronous serial line, idle high
//   READ    : host acknowledge, one-cycle pulse
//   Rx_Data : last accepted byte
//   NINTI   : active-low data-ready
//   FERR    : framing error of the held byte
//   OVR     : sticky overrun flag
// master = line driver / host, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_os_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic                 SI;
  logic                 READ;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 NINTI;
  logic                 FERR;
  logic                 OVR;

  modport master (
    output SI, READ,
    input  Rx_Data, NINTI, FERR, OVR
  );

  modport slave (
    input  SI, READ,
    output Rx_Data, NINTI, FERR, OVR
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Divides the system clock down to the oversample tick rate.
//   i_clk   : system clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_clr   : synchronous clear, restarts the divide phase
//   o_tick  : high for one cycle every BAUD_DIV cycles (when count = BAUD_DIV-1)
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_at_last;

  assign w_at_last = (r_div == DIV_LAST);
  assign o_tick    = w_at_last;

  // Divide counter: wraps at BAUD_DIV-1, clear realigns phase to a new frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div <= {DIV_W{1'b0}};
    end else if (i_clr) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_at_last) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// 16x oversampling UART receiver with a single-byte holding register.
//   i_Clock : system clock, rising edge
//   i_Reset : synchronous active-low reset
//   bus     : slave side of uart_rx_os_if (SI, READ in; Rx_Data, NINTI,
//             FERR, OVR out)
// The line is synchronised, the start bit is qualified by a mid-bit vote,
// each bit is majority-voted from three samples around mid-bit, and the
// stop bit decision delivers the byte (or flags an overrun).
// -----------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  uart_rx_os_if.slave bus
);

  localparam int M     = OVERSAMPLE / 2;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_S0    = SC_W'(M - 1);
  localparam logic [SC_W-1:0]  SC_S1    = SC_W'(M);
  localparam logic [SC_W-1:0]  SC_DEC   = SC_W'(M + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Line synchroniser
  logic r_si_meta;
  logic r_si_sync;
  logic w_s_si;

  // Bit timing and sampling
  logic             w_tick;
  logic             w_clr;
  logic [SC_W-1:0]  r_sc;
  logic             r_s0;
  logic             r_s1;
  logic             w_decide;
  logic             w_vote;

  // Frame tracking
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic                 w_idx_clr;
  logic                 w_idx_inc;
  logic                 w_shift_en;
  logic                 w_deliver;
  logic [DATA_BITS-1:0] r_shift;

  // Host-facing registers
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_ninti;
  logic                 r_ferr;
  logic                 r_ovr;

  assign w_s_si   = r_si_sync;
  // Third vote sample is the live synchronised value at the decision tick
  assign w_decide = w_tick && (r_sc == SC_DEC);
  assign w_vote   = majority3(r_s0, r_s1, w_s_si);

  assign bus.Rx_Data = r_rx_data;
  assign bus.NINTI   = r_ninti;
  assign bus.FERR    = r_ferr;
  assign bus.OVR     = r_ovr;

  // Two-flop synchroniser for the asynchronous line, reset to idle level
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_si_meta <= 1'b1;
      r_si_sync <= 1'b1;
    end else begin
      r_si_meta <= bus.SI;
      r_si_sync <= r_si_meta;
    end
  end

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .i_clk   (i_Clock),
    .i_rst_n (i_Reset),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // Oversample counter, restarted with the divider on start detection
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_sc <= {SC_W{1'b0}};
    end else if (w_clr) begin
      r_sc <= {SC_W{1'b0}};
    end else if (w_tick) begin
      r_sc <= (r_sc == SC_LAST) ? {SC_W{1'b0}} : r_sc + SC_W'(1);
    end else begin
      r_sc <= r_sc;
    end
  end

  // Capture the two early vote samples at sc = M-1 and sc = M
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      r_s0 <= (w_tick && (r_sc == SC_S0)) ? w_s_si : r_s0;
      r_s1 <= (w_tick && (r_sc == SC_S1)) ? w_s_si : r_s1;
    end
  end

  // Frame state register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_s_si) begin
          w_state_nxt = START;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit is treated as a glitch
        if (w_decide) begin
          if (w_vote) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_clr   = 1'b1;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shift_en = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
            w_idx_inc   = 1'b1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        // A low stop bit still delivers the byte, then waits out the break
        if (w_decide) begin
          w_deliver   = 1'b1;
          w_state_nxt = w_vote ? IDLE : BRK;
        end else begin
          w_state_nxt = STOP;
        end
      end
      BRK: begin
        if (w_s_si) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BRK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bit index and LSB-first shift register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_idx   <= {IDX_W{1'b0}};
      r_shift <= {DATA_BITS{1'b0}};
    end else begin
      if (w_idx_clr) begin
        r_idx <= {IDX_W{1'b0}};
      end else if (w_idx_inc) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end
      if (w_shift_en) begin
        r_shift[r_idx] <= w_vote;
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Holding register and host flags; a READ in the delivery cycle frees the
  // holding register in time for the new byte, so NINTI stays low
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_rx_data <= {DATA_BITS{1'b0}};
      r_ninti   <= 1'b1;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (w_deliver) begin
      if (r_ninti || bus.READ) begin
        r_rx_data <= r_shift;
        r_ferr    <= ~w_vote;
        r_ninti   <= 1'b0;
        r_ovr     <= (bus.READ && !r_ninti) ? 1'b0 : r_ovr;
      end else begin
        r_ovr     <= 1'b1;
      end
    end else if (bus.READ && !r_ninti) begin
      r_ninti <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      r_ninti <= r_ninti;
      r_ovr   <= r_ovr;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed plus randomized frames driven on SI; expected host-side values
// come from a byte-level model of the holding register (deliver / overrun /
// read rules) kept in this bench.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int BIT = 4 * 16;  // clocks per bit period

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;
  int   lat_ref;
  logic [7:0] rb;
  int         gap;

  // Reference model of what the host should see
  logic [7:0] exp_data;
  logic       exp_ninti;
  logic       exp_ferr;
  logic       exp_ovr;

  uart_rx_os_if #(.DATA_BITS(8)) bus ();

  uart_rx_os #(
    .BAUD_DIV   (4),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Rx_Data"}, 32'(bus.Rx_Data), 32'(exp_data));
    chk({tag, ".NINTI"},   32'(bus.NINTI),   32'(exp_ninti));
    chk({tag, ".FERR"},    32'(bus.FERR),    32'(exp_ferr));
    chk({tag, ".OVR"},     32'(bus.OVR),     32'(exp_ovr));
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_ninti = 1'b1;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic model_deliver(input logic [7:0] b, input logic fe, input logic rd);
    if (exp_ninti || rd) begin
      if (rd && !exp_ninti) exp_ovr = 1'b0;
      exp_data  = b;
      exp_ferr  = fe;
      exp_ninti = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic model_read();
    if (!exp_ninti) begin
      exp_ninti = 1'b1;
      exp_ovr   = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_pulse(input string tag);
    bus.READ = 1'b1;
    cyc(1);
    bus.READ = 1'b0;
    model_read();
    check_all(tag);
  endtask

  // Drive one frame cycle by cycle. read_at / rst_at select the loop cycle
  // whose values are sampled on the following edge (-1 = never). lat records
  // the edge count from the start bit to NINTI falling.
  task automatic send_frame(input logic [7:0] b, input int stop_bits,
                            input logic stop_val, input int read_at, input int rst_at);
    logic was;
    int   k;
    logic lvl;
    was = bus.NINTI;
    lat = -1;
    for (int c = 0; c < (9 + stop_bits) * BIT; c++) begin
      k = c / BIT;
      if (k == 0)      lvl = 1'b0;
      else if (k <= 8) lvl = b[k-1];
      else             lvl = stop_val;
      bus.SI   = lvl;
      bus.READ = (c == read_at);
      rst_n    = (c == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        model_reset();
        check_all("mid_frame_reset");
      end
      if (lat < 0 && was === 1'b1 && bus.NINTI === 1'b0) lat = c + 1;
    end
    bus.SI   = 1'b1;
    bus.READ = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    bus.SI   = 1'b1;
    bus.READ = 1'b0;
    rst_n    = 1'b0;
    lat_ref  = -1;
    cyc(5);
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    cyc(10);
    check_all("idle");

    // Nominal frame and latency
    send_frame(8'hA5, 1, 1'b1, -1, -1);
    lat_ref = lat;
    chk("a5_latency_window", 32'((lat >= 595) && (lat <= 640)), 32'd1);
    model_deliver(8'hA5, 1'b0, 1'b0);
    check_all("a5");
    read_pulse("a5_read");

    // Short low glitch is rejected
    bus.SI = 1'b0;
    cyc(20);
    bus.SI = 1'b1;
    cyc(2 * BIT);
    check_all("glitch");
    send_frame(8'h3C, 1, 1'b1, -1, -1);
    model_deliver(8'h3C, 1'b0, 1'b0);
    check_all("3c_after_glitch");
    read_pulse("3c_read");

    // Framing error then break: line low for 3 bit periods from stop bit
    send_frame(8'h55, 1, 1'b0, -1, -1);
    bus.SI = 1'b0;
    model_deliver(8'h55, 1'b1, 1'b0);
    check_all("55_ferr");
    chk("brk_state_early", 32'(dut.r_state), 32'(BRK));
    cyc(2 * BIT);
    chk("brk_state_late", 32'(dut.r_state), 32'(BRK));
    check_all("55_during_break");
    bus.SI = 1'b1;
    cyc(BIT);
    read_pulse("55_read");
    send_frame(8'h0F, 1, 1'b1, -1, -1);
    model_deliver(8'h0F, 1'b0, 1'b0);
    check_all("0f_after_break");
    read_pulse("0f_read");

    // Back-to-back frames without READ -> overrun
    send_frame(8'h12, 1, 1'b1, -1, -1);
    model_deliver(8'h12, 1'b0, 1'b0);
    check_all("b2b_12");
    send_frame(8'h34, 1, 1'b1, -1, -1);
    model_deliver(8'h34, 1'b0, 1'b0);
    check_all("b2b_34_overrun");
    read_pulse("b2b_read");

    // READ exactly in the stop-decision cycle, with OVR already set
    send_frame(8'h12, 1, 1'b1, -1, -1);
    model_deliver(8'h12, 1'b0, 1'b0);
    send_frame(8'h77, 1, 1'b1, -1, -1);
    model_deliver(8'h77, 1'b0, 1'b0);
    check_all("pre_coincide");
    send_frame(8'h34, 1, 1'b1, lat_ref - 1, -1);
    model_deliver(8'h34, 1'b0, 1'b1);
    check_all("coincide_34");
    read_pulse("coincide_read");

    // Reset in the middle of the data bits of 0xFF
    send_frame(8'hFF, 1, 1'b1, -1, 4 * BIT + 10);
    check_all("after_abort");
    cyc(BIT);
    send_frame(8'h81, 1, 1'b1, -1, -1);
    model_deliver(8'h81, 1'b0, 1'b0);
    check_all("81_after_reset");

    // Randomized frames, gaps and reads
    for (int i = 0; i < 6; i++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) read_pulse("rand_read");
      cyc(gap * BIT);
      send_frame(rb, 1, 1'b1, -1, -1);
      model_deliver(rb, 1'b0, 1'b0);
      check_all("rand_frame");
    end
    read_pulse("final_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
